// File: rtl/micro_pkg.sv
// Shared definitions for the micro core control path: phase indices,
// sequencer state encoding and default memory timeout.
package micro_pkg;

    localparam int PH_F = 0;
    localparam int PH_R = 1;
    localparam int PH_X = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int NUM_PHASES = 5;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_F     = 3'd1,
        ST_R     = 3'd2,
        ST_X     = 3'd3,
        ST_M     = 3'd4,
        ST_W     = 3'd5,
        ST_HALT  = 3'd6,
        ST_FAULT = 3'd7
    } seq_state_e;

    // One-hot phase for the five instruction phases; zero everywhere else.
    function automatic logic [NUM_PHASES-1:0] phase_decode(input seq_state_e s);
        logic [NUM_PHASES-1:0] p;
        p = '0;
        case (s)
            ST_F:    p[PH_F] = 1'b1;
            ST_R:    p[PH_R] = 1'b1;
            ST_X:    p[PH_X] = 1'b1;
            ST_M:    p[PH_M] = 1'b1;
            ST_W:    p[PH_W] = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Memory handshake and debug register-read port between the phase sequencer
// and the rest of the core / board.
interface phase_sequencer_if #(
    parameter int DBG_AW = 3
);
    // Handshakes:
    //  memory: mem_req is held high for the whole access; the access completes
    //          in the first cycle where mem_req and mem_rdy are both high.
    //          mem_rdy is ignored whenever mem_req is low.
    //  debug:  dbg_req/dbg_addr are held until dbg_ack; dbg_ack is a one-cycle
    //          grant during which rf_ra_sel steers read port 1 to rf_dbg_addr and
    //          the register data is valid. The requester drops dbg_req next cycle.
    logic              mem_req;
    logic              mem_rdy;
    logic              dbg_req;
    logic [DBG_AW-1:0] dbg_addr;
    logic              dbg_ack;
    logic              rf_ra_sel;
    logic [DBG_AW-1:0] rf_dbg_addr;

    modport master (
        output mem_req,
        input  mem_rdy,
        input  dbg_req,
        input  dbg_addr,
        output dbg_ack,
        output rf_ra_sel,
        output rf_dbg_addr
    );

    modport slave (
        input  mem_req,
        output mem_rdy,
        output dbg_req,
        output dbg_addr,
        input  dbg_ack,
        input  rf_ra_sel,
        input  rf_dbg_addr
    );

endinterface

// File: rtl/seq_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access; flags the cycle in
// which one more wait would reach the TIMEOUT limit.
module seq_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic CLK,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expired = (count == LAST);

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle F/R/X/M/W control sequencer with memory wait states, halt,
// run/step modes, timeout fault and register-file read-port-1 debug arbitration.
module phase_sequencer
    import micro_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int DBG_AW  = 3
) (
    input  logic                  CLK,
    input  logic                  n_rst,
    input  logic                  run,
    input  logic                  step,
    input  logic                  hlt,
    input  logic                  mem_op,
    output logic [NUM_PHASES-1:0] phase,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           instr_cnt,
    output seq_state_e            dbg_state,
    phase_sequencer_if.master     bus
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       retire;
    logic       in_access;
    logic       wait_clr;
    logic       wait_en;
    logic       wait_expired;

    assign in_access   = (state_q == ST_F) || (state_q == ST_M);
    assign bus.mem_req = in_access;
    assign dbg_state   = state_q;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run || step) state_d = ST_F;
            end
            ST_F: begin
                if (bus.mem_rdy)       state_d = ST_R;
                else if (wait_expired) state_d = ST_FAULT;
            end
            ST_R: begin
                state_d = ST_X;
            end
            ST_X: begin
                // A halt still retires the halting instruction.
                if (hlt) begin
                    state_d = ST_HALT;
                    retire  = 1'b1;
                end else if (mem_op) begin
                    state_d = ST_M;
                end else begin
                    state_d = ST_W;
                end
            end
            ST_M: begin
                if (bus.mem_rdy)       state_d = ST_W;
                else if (wait_expired) state_d = ST_FAULT;
            end
            ST_W: begin
                retire  = 1'b1;
                state_d = run ? ST_F : ST_IDLE;
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The wait count restarts on every new access; mem_rdy wins over expiry.
    assign wait_clr = ((state_d == ST_F) || (state_d == ST_M)) && (state_d != state_q);
    assign wait_en  = in_access && !bus.mem_rdy;

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .CLK     (CLK),
        .n_rst   (n_rst),
        .clr     (wait_clr),
        .en      (wait_en),
        .expired (wait_expired)
    );

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            phase     <= '0;
            halted    <= 1'b0;
            fault     <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            phase   <= phase_decode(state_d);
            halted  <= (state_d == ST_HALT);
            fault   <= (state_d == ST_FAULT);
            if (retire) instr_cnt <= instr_cnt + 32'd1;
        end
    end

    logic              dbg_ack_q;
    logic [DBG_AW-1:0] dbg_addr_q;
    logic              dbg_grant;

    // The core owns read port 1 in R; the ack cycle itself blocks a
    // back-to-back grant, giving a one-cycle gap between debug reads.
    assign dbg_grant = bus.dbg_req && !dbg_ack_q && (state_d != ST_R);

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            dbg_ack_q  <= 1'b0;
            dbg_addr_q <= '0;
        end else begin
            dbg_ack_q <= dbg_grant;
            if (dbg_grant) dbg_addr_q <= bus.dbg_addr;
        end
    end

    assign bus.dbg_ack     = dbg_ack_q;
    assign bus.rf_ra_sel   = dbg_ack_q;
    assign bus.rf_dbg_addr = dbg_addr_q;

endmodule
